// File: rtl/reset_seq_defs.sv
// Shared definitions for the reset sequencer: FSM state encodings, reset-cause codes
// and the saturating request-counter helper.
package reset_seq_defs;

    typedef enum logic [1:0] {
        StAssert  = 2'b00,
        StRelease = 2'b01,
        StRun     = 2'b10
    } state_e;

    localparam logic [1:0] CAUSE_EXT = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rst_timer.sv
// 8-bit hold/gap down-counter shared by the assert and release phases.
// Stops at zero; zero_o flags expiry.
module rst_timer #(
    parameter int unsigned RstVal = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [7:0] cnt_q = 8'(RstVal);
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'(RstVal);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/reset_seq.sv
// Staged reset sequencer: holds all domains in reset, then releases them one by one,
// re-entering the sequence on watchdog or software requests.
module reset_seq
    import reset_seq_defs::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned N_STAGES    = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wdt_rst_req,
    input  logic                i_sw_rst_req,
    output logic [N_STAGES-1:0] o_rst_stage,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_cause,
    output logic [7:0]          o_rst_count
);

    // Set bits are always contiguous at the top, so only the MSB left means last stage.
    localparam logic [N_STAGES-1:0] LastOnly = N_STAGES'(1) << (N_STAGES - 1);
    // The accepting edge itself counts as the first hold cycle.
    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GapLoad  = 8'(STAGE_GAP - 1);

    state_e              state_q = StAssert;
    state_e              state_d;
    logic [N_STAGES-1:0] stage_q = '1;
    logic [N_STAGES-1:0] stage_d;
    logic                busy_q  = 1'b1;
    logic                busy_d;
    logic                done_q  = 1'b0;
    logic                done_d;
    logic [1:0]          cause_q = CAUSE_EXT;
    logic [1:0]          cause_d;
    logic [7:0]          count_q = 8'd0;
    logic [7:0]          count_d;

    logic                tmr_load;
    logic [7:0]          tmr_val;
    logic                tmr_dec;
    logic                tmr_zero;
    logic                accept;
    logic [1:0]          acc_cause;

    rst_timer #(
        .RstVal(HOLD_CYCLES)
    ) u_timer (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .dec_i     (tmr_dec),
        .zero_o    (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        cause_d   = cause_q;
        count_d   = count_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = HoldLoad;
        tmr_dec   = 1'b0;
        accept    = 1'b0;
        acc_cause = CAUSE_WDT;

        // Software requests only count once the sequence has completed.
        if (i_wdt_rst_req) begin
            accept = 1'b1;
        end else if (i_sw_rst_req && (state_q == StRun)) begin
            accept    = 1'b1;
            acc_cause = CAUSE_SW;
        end

        if (accept) begin
            state_d  = StAssert;
            stage_d  = '1;
            cause_d  = acc_cause;
            count_d  = sat_inc(count_q);
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                StAssert, StRelease: begin
                    if (tmr_zero) begin
                        stage_d  = stage_q << 1;
                        tmr_load = 1'b1;
                        tmr_val  = GapLoad;
                        if (stage_q == LastOnly) begin
                            state_d = StRun;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRelease;
                        end
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                StRun: begin
                    state_d = StRun;
                end
                default: begin
                    state_d  = StAssert;
                    stage_d  = '1;
                    tmr_load = 1'b1;
                end
            endcase
        end

        busy_d = |stage_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StAssert;
            stage_q <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cause_q <= CAUSE_EXT;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    assign o_rst_stage = stage_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_cause     = cause_q;
    assign o_rst_count = count_q;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: directed vector table, hand-written corner
// sequences and random traffic against a release-schedule reference model.
module tb_reset_seq;

    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int NS   = 3;
    localparam int LAST = HOLD + (NS - 1) * GAP;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_wdt = 1'b0;
    logic          i_sw = 1'b0;
    logic [NS-1:0] o_rst_stage;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_cause;
    logic [7:0]    o_rst_count;

    always #5 clk = ~clk;

    reset_seq #(
        .HOLD_CYCLES(HOLD),
        .STAGE_GAP  (GAP),
        .N_STAGES   (NS)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_wdt_rst_req(i_wdt),
        .i_sw_rst_req (i_sw),
        .o_rst_stage  (o_rst_stage),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cause      (o_cause),
        .o_rst_count  (o_rst_count)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         t        = 0;
    // Model: a sequence anchored at edge A releases stage k at edge A+HOLD+k*GAP.
    int         anchor   = 1;
    logic [1:0] m_cause  = 2'd0;
    int         m_count  = 0;

    typedef struct {
        logic       r;
        logic       w;
        logic       s;
        int         hold;
        logic [2:0] stage;
        logic       busy;
        logic       done;
        logic [1:0] cause;
        logic [7:0] count;
    } vec_t;

    vec_t vec[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    function automatic logic [NS-1:0] m_stage();
        logic [NS-1:0] s;
        for (int k = 0; k < NS; k++) s[k] = (t < anchor + HOLD + k * GAP);
        return s;
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic s);
        bit running;
        running = (t - 1) >= anchor + LAST;
        if (r) begin
            anchor  = t + 1;
            m_cause = 2'd0;
            m_count = 0;
        end else if (w || (s && running)) begin
            anchor  = t;
            m_cause = w ? 2'd2 : 2'd1;
            m_count = (m_count >= 255) ? 255 : m_count + 1;
        end
    endtask

    task automatic check_model();
        logic [NS-1:0] es;
        es = m_stage();
        check("model_stage", 32'(o_rst_stage), 32'(es));
        check("model_busy", 32'(o_busy), 32'(|es));
        check("model_done", 32'(o_done), 32'(t == anchor + LAST));
        check("model_cause", 32'(o_cause), 32'(m_cause));
        check("model_count", 32'(o_rst_count), 32'(m_count));
    endtask

    task automatic step(input logic r, input logic w, input logic s);
        i_rst = r;
        i_wdt = w;
        i_sw  = s;
        @(posedge clk);
        model_edge(r, w, s);
        @(negedge clk);
        check_model();
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_out(input string name, input logic [2:0] st, input logic dn,
                             input logic [1:0] ca, input logic [7:0] cn);
        check({name, "_stage"}, 32'(o_rst_stage), 32'(st));
        check({name, "_done"}, 32'(o_done), 32'(dn));
        check({name, "_cause"}, 32'(o_cause), 32'(ca));
        check({name, "_count"}, 32'(o_rst_count), 32'(cn));
    endtask

    initial begin
        vec[0]  = '{1'b1, 1'b0, 1'b0,  3, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 16, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[2]  = '{1'b0, 1'b0, 1'b0,  1, 3'b110, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[3]  = '{1'b0, 1'b0, 1'b0,  4, 3'b100, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[4]  = '{1'b0, 1'b0, 1'b0,  3, 3'b100, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[5]  = '{1'b0, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b1, 2'd0, 8'd0};
        vec[6]  = '{1'b0, 1'b0, 1'b0,  2, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
        vec[7]  = '{1'b0, 1'b0, 1'b1,  1, 3'b111, 1'b1, 1'b0, 2'd1, 8'd1};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 15, 3'b111, 1'b1, 1'b0, 2'd1, 8'd1};
        vec[9]  = '{1'b0, 1'b0, 1'b0,  1, 3'b110, 1'b1, 1'b0, 2'd1, 8'd1};
        vec[10] = '{1'b0, 1'b0, 1'b0,  4, 3'b100, 1'b1, 1'b0, 2'd1, 8'd1};
        vec[11] = '{1'b0, 1'b0, 1'b0,  4, 3'b000, 1'b0, 1'b1, 2'd1, 8'd1};
        vec[12] = '{1'b0, 1'b1, 1'b1,  1, 3'b111, 1'b1, 1'b0, 2'd2, 8'd2};
        vec[13] = '{1'b0, 1'b0, 1'b0, 17, 3'b110, 1'b1, 1'b0, 2'd2, 8'd2};
        vec[14] = '{1'b0, 1'b1, 1'b0,  1, 3'b111, 1'b1, 1'b0, 2'd2, 8'd3};
        vec[15] = '{1'b0, 1'b0, 1'b0, 15, 3'b111, 1'b1, 1'b0, 2'd2, 8'd3};
        vec[16] = '{1'b0, 1'b0, 1'b0,  1, 3'b110, 1'b1, 1'b0, 2'd2, 8'd3};
        vec[17] = '{1'b0, 1'b0, 1'b0,  4, 3'b100, 1'b1, 1'b0, 2'd2, 8'd3};
        vec[18] = '{1'b0, 1'b0, 1'b0,  4, 3'b000, 1'b0, 1'b1, 2'd2, 8'd3};
        vec[19] = '{1'b1, 1'b1, 1'b1,  1, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[20] = '{1'b0, 1'b0, 1'b0, 10, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[21] = '{1'b0, 1'b0, 1'b1,  1, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[22] = '{1'b0, 1'b0, 1'b0,  6, 3'b110, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[23] = '{1'b0, 1'b0, 1'b0,  5, 3'b100, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[24] = '{1'b1, 1'b0, 1'b0,  1, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0};
        vec[25] = '{1'b0, 1'b0, 1'b0, 25, 3'b000, 1'b0, 1'b1, 2'd0, 8'd0};

        #1;
        check("powerup_stage", 32'(o_rst_stage), 32'(3'b111));
        check("powerup_busy", 32'(o_busy), 32'(1'b1));
        check_out("powerup", 3'b111, 1'b0, 2'd0, 8'd0);
        @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            for (int c = 0; c < vec[i].hold; c++) step(vec[i].r, vec[i].w, vec[i].s);
            check($sformatf("vec%0d_stage", i), 32'(o_rst_stage), 32'(vec[i].stage));
            check($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vec[i].busy));
            check($sformatf("vec%0d_done", i), 32'(o_done), 32'(vec[i].done));
            check($sformatf("vec%0d_cause", i), 32'(o_cause), 32'(vec[i].cause));
            check($sformatf("vec%0d_count", i), 32'(o_rst_count), 32'(vec[i].count));
        end

        // Software request held as a level across completion is taken on the first RUN cycle.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1);
        check_out("sw_level_done", 3'b000, 1'b1, 2'd0, 8'd0);
        step(1'b0, 1'b0, 1'b1);
        check_out("sw_level_take", 3'b111, 1'b0, 2'd1, 8'd1);
        idle(24);
        check_out("sw_level_end", 3'b000, 1'b1, 2'd1, 8'd1);

        // Counter saturation under a long run of watchdog requests.
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
        check_out("wdt_sat", 3'b111, 1'b0, 2'd2, 8'd255);
        idle(24);
        check_out("wdt_sat_end", 3'b000, 1'b1, 2'd2, 8'd255);
        step(1'b0, 1'b0, 1'b1);
        check_out("sat_sw", 3'b111, 1'b0, 2'd1, 8'd255);
        idle(24);
        check_out("sat_sw_end", 3'b000, 1'b1, 2'd1, 8'd255);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
